// File: rtl/ekf_pkg.sv
// Shared definitions for the EKF stage sequencer: stage one-hot codes,
// sequencer FSM states and an elaboration-time log2 helper.
package ekf_pkg;

  localparam logic [2:0] STAGE_IDLE = 3'b000;
  localparam logic [2:0] STAGE_PRD  = 3'b001;
  localparam logic [2:0] STAGE_NEW  = 3'b010;
  localparam logic [2:0] STAGE_UPD  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Ceiling log2; returns 0 for an argument of 1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ekf_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra MSB so that full and
// empty are distinguished without a separate occupancy register.
module ekf_cmd_fifo
  import ekf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [WIDTH-1:0]        i_data,
  output logic [WIDTH-1:0]        o_head,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [clog2(DEPTH):0]   o_cnt
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_cnt   = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ekf_stage_sequencer.sv
// Queued command front-end for the EKF-SLAM Top: buffers stage commands and
// issues each as a stage_val pulse, tracking stage_rdy through to completion.
module ekf_stage_sequencer
  import ekf_pkg::*;
#(
  parameter int RSA_DW     = 32,
  parameter int RSA_AW     = 17,
  parameter int ROW_LEN    = 10,
  parameter int STAGE_NUM  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_LEN  = 2,
  parameter int ACK_TO     = 64
) (
  input  logic                        clk,
  input  logic                        sys_rst,
  input  logic                        cmd_val,
  output logic                        cmd_rdy,
  input  logic [STAGE_NUM-1:0]        cmd_stage,
  input  logic [ROW_LEN-1:0]          cmd_l_k,
  input  logic [RSA_DW-1:0]           cmd_vlr,
  input  logic [RSA_AW-1:0]           cmd_alpha,
  input  logic [RSA_DW-1:0]           cmd_rk,
  input  logic [RSA_AW-1:0]           cmd_phi,
  output logic [STAGE_NUM-1:0]        stage_val,
  input  logic [STAGE_NUM-1:0]        stage_rdy,
  output logic [ROW_LEN-1:0]          l_k,
  output logic [RSA_DW-1:0]           vlr,
  output logic [RSA_AW-1:0]           alpha,
  output logic [RSA_DW-1:0]           rk,
  output logic [RSA_AW-1:0]           phi,
  output logic                        busy,
  output logic                        done,
  output logic [STAGE_NUM-1:0]        done_stage,
  output logic                        err_cmd,
  output logic                        err_to,
  output logic [clog2(FIFO_DEPTH):0]  fifo_cnt,
  output state_t                      o_dbg_state
);

  localparam int FW = STAGE_NUM + ROW_LEN + 2*RSA_DW + 2*RSA_AW;
  localparam int PW = clog2(PULSE_LEN) + 1;
  localparam int TW = clog2(ACK_TO) + 1;

  logic [FW-1:0]        w_fifo_din;
  logic [FW-1:0]        w_fifo_head;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [STAGE_NUM-1:0] w_head_stage;
  logic [ROW_LEN-1:0]   w_head_l_k;
  logic [RSA_DW-1:0]    w_head_vlr;
  logic [RSA_AW-1:0]    w_head_alpha;
  logic [RSA_DW-1:0]    w_head_rk;
  logic [RSA_AW-1:0]    w_head_phi;
  logic                 w_accept;
  logic                 w_cmd_onehot;
  logic                 w_pop;
  logic                 w_sel_rdy;
  state_t               w_nxt_state;

  state_t               r_state;
  logic                 r_rdy_en;
  logic [STAGE_NUM-1:0] r_stage;
  logic [STAGE_NUM-1:0] r_stage_val;
  logic [PW-1:0]        r_pulse_cnt;
  logic [TW-1:0]        r_to_cnt;
  logic                 r_acked;
  logic                 r_err_cmd;
  logic                 r_err_to;
  logic [ROW_LEN-1:0]   r_l_k;
  logic [RSA_DW-1:0]    r_vlr;
  logic [RSA_AW-1:0]    r_alpha;
  logic [RSA_DW-1:0]    r_rk;
  logic [RSA_AW-1:0]    r_phi;

  // Handshake: a command transfers on a rising clk edge where cmd_val && cmd_rdy;
  // cmd_rdy never depends on cmd_val. Illegal (non-one-hot) commands transfer too,
  // but are dropped instead of stored.
  assign cmd_rdy      = r_rdy_en && !w_fifo_full;
  assign w_accept     = cmd_val && cmd_rdy;
  assign w_cmd_onehot = (cmd_stage != '0) && ((cmd_stage & (cmd_stage - 1'b1)) == '0);
  assign w_fifo_din   = {cmd_stage, cmd_l_k, cmd_vlr, cmd_alpha, cmd_rk, cmd_phi};
  assign {w_head_stage, w_head_l_k, w_head_vlr, w_head_alpha, w_head_rk, w_head_phi} = w_fifo_head;
  assign w_sel_rdy    = |(stage_rdy & r_stage);

  ekf_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (clk),
    .i_rst_n (sys_rst),
    .i_push  (w_accept && w_cmd_onehot),
    .i_pop   (w_pop),
    .i_data  (w_fifo_din),
    .o_head  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_cnt   (fifo_cnt)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty && (|(stage_rdy & w_head_stage))) begin
          w_pop       = 1'b1;
          w_nxt_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An acknowledge already seen during the pulse skips WAIT_ACK entirely.
        if (r_pulse_cnt == PW'(PULSE_LEN - 1))
          w_nxt_state = (r_acked || !w_sel_rdy) ? S_WAIT_DONE : S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!w_sel_rdy)                         w_nxt_state = S_WAIT_DONE;
        else if (r_to_cnt == TW'(ACK_TO - 1))   w_nxt_state = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (w_sel_rdy) w_nxt_state = S_DONE;
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state     <= S_IDLE;
      r_rdy_en    <= 1'b0;
      r_stage     <= '0;
      r_stage_val <= '0;
      r_pulse_cnt <= '0;
      r_to_cnt    <= '0;
      r_acked     <= 1'b0;
      r_err_cmd   <= 1'b0;
      r_err_to    <= 1'b0;
      r_l_k       <= '0;
      r_vlr       <= '0;
      r_alpha     <= '0;
      r_rk        <= '0;
      r_phi       <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_rdy_en  <= 1'b1;
      r_err_cmd <= w_accept && !w_cmd_onehot;
      r_err_to  <= (r_state == S_WAIT_ACK) && (w_nxt_state == S_IDLE);
      r_to_cnt  <= (r_state == S_WAIT_ACK) ? r_to_cnt + 1'b1 : '0;
      if (w_pop) begin
        r_stage     <= w_head_stage;
        r_l_k       <= w_head_l_k;
        r_vlr       <= w_head_vlr;
        r_alpha     <= w_head_alpha;
        r_rk        <= w_head_rk;
        r_phi       <= w_head_phi;
        r_pulse_cnt <= '0;
        r_acked     <= 1'b0;
      end else if (r_state == S_ISSUE) begin
        r_pulse_cnt <= r_pulse_cnt + 1'b1;
        if (!w_sel_rdy) r_acked <= 1'b1;
      end
      if (w_nxt_state == S_ISSUE) r_stage_val <= w_pop ? w_head_stage : r_stage;
      else                        r_stage_val <= '0;
    end
  end

  assign stage_val   = r_stage_val;
  assign l_k         = r_l_k;
  assign vlr         = r_vlr;
  assign alpha       = r_alpha;
  assign rk          = r_rk;
  assign phi         = r_phi;
  assign busy        = (r_state != S_IDLE) || !w_fifo_empty;
  assign done        = (r_state == S_DONE);
  assign done_stage  = (r_state == S_DONE) ? r_stage : '0;
  assign err_cmd     = r_err_cmd;
  assign err_to      = r_err_to;
  assign o_dbg_state = r_state;

endmodule

// File: doc/ekf_stage_sequencer.md
Name: ekf_stage_sequencer

Overview:
- Queued command front-end for the EKF-SLAM Top accelerator. Replaces hand-driven stage_val pulses.
- Accepts stage commands (one-hot stage plus its operands) into a FIFO. Issues each command to Top as a stage_val pulse of programmable length, then tracks the stage_rdy handshake through to completion.
- Generalised over stage count, queue depth and pulse length. Adds acknowledge timeout, illegal-command rejection and completion reporting.

Parameters:
- RSA_DW, 32, operand data width (vlr, rk)
- RSA_AW, 17, angle width (alpha, phi)
- ROW_LEN, 10, landmark index width (l_k)
- STAGE_NUM, 3, number of one-hot stage bits (PRD=001, NEW=010, UPD=100)
- FIFO_DEPTH, 4, command queue depth; power of two, at least 2
- PULSE_LEN, 2, cycles stage_val is held per issue; at least 1
- ACK_TO, 64, maximum cycles allowed for stage_rdy to drop after issue

Ports:
- clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-low reset
- cmd_val  in  1  command valid
- cmd_rdy  out  1  command accepted when cmd_val && cmd_rdy
- cmd_stage  in  STAGE_NUM  one-hot stage select
- cmd_l_k  in  ROW_LEN  landmark index operand
- cmd_vlr  in  RSA_DW  velocity operand
- cmd_alpha  in  RSA_AW  steering angle operand
- cmd_rk  in  RSA_DW  range operand
- cmd_phi  in  RSA_AW  bearing operand
- stage_val  out  STAGE_NUM  stage request to Top
- stage_rdy  in  STAGE_NUM  Top per-stage ready; high means idle
- l_k, vlr, alpha, rk, phi  out  as cmd_*  operands to Top, held stable from issue until DONE
- busy  out  1  FSM not in IDLE, or FIFO not empty
- done  out  1  one-cycle completion pulse
- done_stage  out  STAGE_NUM  stage that completed; valid with done
- err_cmd  out  1  one-cycle pulse when a non-one-hot command is dropped
- err_to  out  1  one-cycle pulse on acknowledge timeout
- fifo_cnt  out  log2(FIFO_DEPTH)+1  current queue occupancy

Behaviour:
Reset:
- While sys_rst is low: all outputs are 0, the FIFO is emptied and the FSM is in IDLE.
- cmd_rdy goes to 1 on the first clock after reset is released.
- Reset asserted mid-operation aborts the command immediately; stage_val drops asynchronously.

Command input:
- cmd_rdy = fifo_cnt < FIFO_DEPTH.
- A command whose cmd_stage is not one-hot (zero, or more than one bit set) is still handshaken. It is not stored and err_cmd pulses on the next cycle.
- Push and pop in the same cycle are allowed, including when the FIFO is full (cmd_rdy is 0 when full, so no push happens). fifo_cnt stays unchanged on simultaneous push and pop.

FSM states:
- IDLE: if the FIFO is not empty and stage_rdy & head.stage is non-zero, pop the head into the operand registers and go to ISSUE. Otherwise stay in IDLE; the head is not popped while its stage is not ready.
- ISSUE: stage_val = latched stage for exactly PULSE_LEN cycles, counted by pulse_cnt. Then go to WAIT_ACK.
- WAIT_ACK: wait for the selected stage_rdy bit to be 0. If it drops during ISSUE, that counts and the FSM goes straight to WAIT_DONE after the pulse. If ACK_TO cycles elapse with no drop, pulse err_to and return to IDLE; the command is discarded.
- WAIT_DONE: wait for the selected stage_rdy bit to return to 1, then go to DONE. There is no timeout, since update latency scales with landmark_num.
- DONE: 1 cycle. done=1, done_stage=latched stage. Then go to IDLE.

Latency and timing:
- Minimum latency from push into an empty FIFO to stage_val asserted is 2 cycles: 1 cycle of FIFO write, 1 cycle of IDLE pop.
- Operand outputs change only on pop.
- stage_val is registered and glitch-free.

Decomposition:
- Shared package ekf_pkg holds: stage one-hot constants IDLE/STAGE_PRD/STAGE_NEW/STAGE_UPD, FSM state encodings, and a clog2 function.
- One sub-module, ekf_cmd_fifo. It is a synchronous FIFO, width STAGE_NUM+ROW_LEN+2*RSA_DW+2*RSA_AW, depth FIFO_DEPTH. It has count output and wrap-around pointers with an extra MSB for full/empty.

Test Plan:
1. Reset, then push PRD with vlr=2, alpha=3, rk=4, phi=5. Top model drops stage_rdy[0] 1 cycle after stage_val and restores it 20 cycles later. Required: stage_val=001 for 2 cycles; outputs hold 2/3/4/5; done pulses with done_stage=001.
2. Push 4 commands (PRD, NEW, UPD with l_k=2, PRD) while Top is busy. Required: cmd_rdy=0 with fifo_cnt=4; a fifth cmd_val is held off; stages are issued in order with one done per command.
3. Push cmd_stage=011, then cmd_stage=000. Required: two err_cmd pulses; fifo_cnt stays 0; stage_val is never asserted.
4. Top never drops stage_rdy after issue. Required: err_to pulses exactly ACK_TO cycles after entry into WAIT_ACK; FSM returns to IDLE; the next queued command issues.
5. Hold stage_rdy[2]=0 with UPD at the head. Required: no pop and no stage_val. Release stage_rdy[2]=1; issue follows within 1 cycle.
6. Assert sys_rst low during WAIT_DONE with 2 commands queued. Required: stage_val=0 and fifo_cnt=0 asynchronously; after release, cmd_rdy=1 and no stale done.
